// File: rtl/link_pipe.sv
// Carries JAL/JALR/BxxZAL return-address writes through the E, M and W pipeline registers.
// Also forwards in-flight return addresses back to the D-stage comparators.
module link_pipe #(
   parameter int LINK_REG  = 31,
   parameter int PC_OFFSET = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallE,
   input  logic        flushE,
   input  logic        stallM,
   input  logic        flushM,
   input  logic        stallW,
   input  logic        flushW,
   input  logic        linkD,
   input  logic        linkPCD,
   input  logic [31:0] pcD,
   input  logic [4:0]  rdD,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   output logic        link_wrE,
   output logic [4:0]  link_regE,
   output logic [31:0] link_dataE,
   output logic        link_wrM,
   output logic [4:0]  link_regM,
   output logic [31:0] link_dataM,
   output logic        link_wrW,
   output logic [4:0]  link_regW,
   output logic [31:0] link_dataW,
   output logic        fwd_rs_hit,
   output logic [31:0] fwd_rs_data,
   output logic        fwd_rt_hit,
   output logic [31:0] fwd_rt_data
);

   localparam logic [4:0]  LinkRegIdx = 5'(LINK_REG);
   localparam logic [31:0] PcOffset   = 32'(PC_OFFSET);

   logic        w_wrD;
   logic [4:0]  w_regD;
   logic [31:0] w_dataD;

   logic        r_wrE, r_wrM, r_wrW;
   logic [4:0]  r_regE, r_regM, r_regW;
   logic [31:0] r_dataE, r_dataM, r_dataW;

   // A write to $0 is architecturally a no-op, so it never enables a write or a forward.
   always_comb begin
      w_regD  = linkD ? LinkRegIdx : rdD;
      w_dataD = pcD + PcOffset;
      w_wrD   = linkPCD && (w_regD != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst || flushE) begin
         r_wrE   <= 1'b0;
         r_regE  <= 5'd0;
         r_dataE <= 32'd0;
      end else if (!stallE) begin
         r_wrE   <= w_wrD;
         r_regE  <= w_regD;
         r_dataE <= w_dataD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flushM) begin
         r_wrM   <= 1'b0;
         r_regM  <= 5'd0;
         r_dataM <= 32'd0;
      end else if (!stallM) begin
         r_wrM   <= r_wrE;
         r_regM  <= r_regE;
         r_dataM <= r_dataE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flushW) begin
         r_wrW   <= 1'b0;
         r_regW  <= 5'd0;
         r_dataW <= 32'd0;
      end else if (!stallW) begin
         r_wrW   <= r_wrM;
         r_regW  <= r_regM;
         r_dataW <= r_dataM;
      end
   end

   // Youngest matching entry wins; bit 32 of the result is the hit flag.
   function automatic logic [32:0] lookup(
      input logic [4:0]  src,
      input logic        wrE, input logic [4:0] regE, input logic [31:0] dataE,
      input logic        wrM, input logic [4:0] regM, input logic [31:0] dataM,
      input logic        wrW, input logic [4:0] regW, input logic [31:0] dataW
   );
      logic [32:0] res;
      res = 33'd0;
      if (src != 5'd0) begin
         if (wrE && regE == src)      res = {1'b1, dataE};
         else if (wrM && regM == src) res = {1'b1, dataM};
         else if (wrW && regW == src) res = {1'b1, dataW};
      end
      return res;
   endfunction

   always_comb begin
      {fwd_rs_hit, fwd_rs_data} = lookup(rsD, r_wrE, r_regE, r_dataE,
                                         r_wrM, r_regM, r_dataM,
                                         r_wrW, r_regW, r_dataW);
      {fwd_rt_hit, fwd_rt_data} = lookup(rtD, r_wrE, r_regE, r_dataE,
                                         r_wrM, r_regM, r_dataM,
                                         r_wrW, r_regW, r_dataW);
   end

   assign link_wrE   = r_wrE;
   assign link_regE  = r_regE;
   assign link_dataE = r_dataE;
   assign link_wrM   = r_wrM;
   assign link_regM  = r_regM;
   assign link_dataM = r_dataM;
   assign link_wrW   = r_wrW;
   assign link_regW  = r_regW;
   assign link_dataW = r_dataW;

endmodule

// File: tb/tb_link_pipe.sv
// Scoreboard bench for link_pipe: stimulus queues expected stage/forward values tagged
// with the cycle they must appear, and a monitor compares them after each rising edge.
module tb_link_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallE = 0, flushE = 0, stallM = 0, flushM = 0, stallW = 0, flushW = 0;
   logic        linkD = 0, linkPCD = 0;
   logic [31:0] pcD = 0;
   logic [4:0]  rdD = 0, rsD = 0, rtD = 0;

   logic        link_wrE, link_wrM, link_wrW;
   logic [4:0]  link_regE, link_regM, link_regW;
   logic [31:0] link_dataE, link_dataM, link_dataW;
   logic        fwd_rs_hit, fwd_rt_hit;
   logic [31:0] fwd_rs_data, fwd_rt_data;

   link_pipe dut (
      .clk(clk), .rst(rst),
      .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
      .stallW(stallW), .flushW(flushW),
      .linkD(linkD), .linkPCD(linkPCD), .pcD(pcD), .rdD(rdD), .rsD(rsD), .rtD(rtD),
      .link_wrE(link_wrE), .link_regE(link_regE), .link_dataE(link_dataE),
      .link_wrM(link_wrM), .link_regM(link_regM), .link_dataM(link_dataM),
      .link_wrW(link_wrW), .link_regW(link_regW), .link_dataW(link_dataW),
      .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
      .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data)
   );

   always #5 clk = ~clk;

   localparam int ST_E = 0, ST_M = 1, ST_W = 2, ST_RS = 3, ST_RT = 4;

   typedef struct {
      int          cyc;
      string       name;
      int          stage;
      logic        wr;
      logic [4:0]  rg;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic        rst, stE, flE, stM, flM, stW, flW, lD, lPC;
      logic [31:0] pc;
      logic [4:0]  rd, rs, rt;
   } stim_t;

   exp_t sb[$];
   int   cyc = 0;
   int   nCompared = 0;
   int   nMismatched = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t jal(input logic [31:0] pc);
      stim_t s;
      s = idle();
      s.lD = 1'b1; s.lPC = 1'b1; s.pc = pc;
      return s;
   endfunction

   function automatic stim_t jalr(input logic [4:0] rd, input logic [31:0] pc);
      stim_t s;
      s = idle();
      s.lPC = 1'b1; s.rd = rd; s.pc = pc;
      return s;
   endfunction

   // Inputs change on the falling edge so the next rising edge captures them.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      rst = s.rst;
      stallE = s.stE; flushE = s.flE;
      stallM = s.stM; flushM = s.flM;
      stallW = s.stW; flushW = s.flW;
      linkD = s.lD; linkPCD = s.lPC;
      pcD = s.pc; rdD = s.rd; rsD = s.rs; rtD = s.rt;
   endtask

   task automatic expectAt(input string name, input int stage, input int dt,
                           input logic wr, input logic [4:0] rg, input logic [31:0] data);
      exp_t e;
      e.cyc = cyc + dt; e.name = name; e.stage = stage;
      e.wr = wr; e.rg = rg; e.data = data;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic        aWr;
      logic [4:0]  aRg;
      logic [31:0] aData;
      aWr = 1'b0; aRg = 5'd0; aData = 32'd0;
      case (e.stage)
         ST_E:    begin aWr = link_wrE; aRg = link_regE; aData = link_dataE; end
         ST_M:    begin aWr = link_wrM; aRg = link_regM; aData = link_dataM; end
         ST_W:    begin aWr = link_wrW; aRg = link_regW; aData = link_dataW; end
         ST_RS:   begin aWr = fwd_rs_hit; aRg = e.rg; aData = fwd_rs_data; end
         default: begin aWr = fwd_rt_hit; aRg = e.rg; aData = fwd_rt_data; end
      endcase
      nCompared++;
      if (aWr !== e.wr || aRg !== e.rg || aData !== e.data) begin
         nMismatched++;
         $display("[TB] FAIL %s (cycle %0d): got wr/hit=%b reg=%0d data=%h, required wr/hit=%b reg=%0d data=%h",
                  e.name, cyc, aWr, aRg, aData, e.wr, e.rg, e.data);
      end
   endtask

   // Monitor: after each rising edge, check every expectation due this cycle.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               checkOutput(sb[i]);
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      stim_t s;

      s = idle(); s.rst = 1'b1;
      applyStimulus(s);
      expectAt("reset_E", ST_E, 1, 0, 0, 32'h0);
      expectAt("reset_M", ST_M, 1, 0, 0, 32'h0);
      expectAt("reset_W", ST_W, 1, 0, 0, 32'h0);
      expectAt("reset_rs", ST_RS, 1, 0, 0, 32'h0);
      expectAt("reset_rt", ST_RT, 1, 0, 0, 32'h0);

      applyStimulus(jal(32'hBFC00100));
      expectAt("jal_E", ST_E, 1, 1, 31, 32'hBFC00108);
      expectAt("jal_M", ST_M, 2, 1, 31, 32'hBFC00108);
      expectAt("jal_W", ST_W, 3, 1, 31, 32'hBFC00108);
      // The idle D slot has pcD=0, so the following E entry carries data 8 with wr=0.
      expectAt("jal_E_after", ST_E, 2, 0, 0, 32'h00000008);
      applyStimulus(idle());
      applyStimulus(idle());
      applyStimulus(idle());

      applyStimulus(jalr(5'd5, 32'h00400010));
      expectAt("jalr5_E", ST_E, 1, 1, 5, 32'h00400018);
      expectAt("jalr5_M", ST_M, 2, 1, 5, 32'h00400018);
      expectAt("jalr5_W", ST_W, 3, 1, 5, 32'h00400018);
      applyStimulus(jalr(5'd0, 32'h00400010));
      expectAt("jalr0_E", ST_E, 1, 0, 0, 32'h00400018);
      expectAt("jalr0_M", ST_M, 2, 0, 0, 32'h00400018);
      expectAt("jalr0_W", ST_W, 3, 0, 0, 32'h00400018);
      applyStimulus(jal(32'hFFFFFFFC));
      expectAt("wrap_E", ST_E, 1, 1, 31, 32'h00000004);
      s = idle(); s.lD = 1'b1; s.pc = 32'h00001000;
      applyStimulus(s);
      expectAt("linkD_noPC_E", ST_E, 1, 0, 31, 32'h00001008);

      applyStimulus(jal(32'h00002000));
      expectAt("stall_load_E", ST_E, 1, 1, 31, 32'h00002008);
      s = jalr(5'd3, 32'h00003000); s.stE = 1'b1;
      applyStimulus(s);
      expectAt("stall1_E", ST_E, 1, 1, 31, 32'h00002008);
      expectAt("stall1_M", ST_M, 1, 1, 31, 32'h00002008);
      applyStimulus(s);
      expectAt("stall2_E", ST_E, 1, 1, 31, 32'h00002008);
      s.flE = 1'b1;
      applyStimulus(s);
      expectAt("stall_flushE_E", ST_E, 1, 0, 0, 32'h0);
      expectAt("stall_flushE_M", ST_M, 1, 1, 31, 32'h00002008);

      applyStimulus(jal(32'h00004000));
      expectAt("pre_flushM_W", ST_W, 1, 1, 31, 32'h00002008);
      s = idle(); s.flM = 1'b1;
      applyStimulus(s);
      expectAt("flushM_M", ST_M, 1, 0, 0, 32'h0);
      expectAt("flushM_W", ST_W, 1, 0, 0, 32'h0);

      applyStimulus(jalr(5'd8, 32'h000001F8));
      s = jalr(5'd8, 32'h000000F8); s.rs = 5'd8; s.rt = 5'd0;
      applyStimulus(s);
      expectAt("fwd_E_over_M_rs", ST_RS, 1, 1, 0, 32'h00000100);
      expectAt("fwd_rt_zero", ST_RT, 1, 0, 0, 32'h0);
      s = idle(); s.flE = 1'b1; s.stM = 1'b1; s.rs = 5'd8; s.rt = 5'd8;
      applyStimulus(s);
      expectAt("fwd_after_flushE_rs", ST_RS, 1, 1, 0, 32'h00000200);
      expectAt("fwd_after_flushE_rt", ST_RT, 1, 1, 0, 32'h00000200);
      s = idle(); s.flM = 1'b1; s.rs = 5'd8; s.rt = 5'd5;
      applyStimulus(s);
      expectAt("fwd_from_W_rs", ST_RS, 1, 1, 0, 32'h00000200);
      expectAt("fwd_miss_rt", ST_RT, 1, 0, 0, 32'h0);

      applyStimulus(jal(32'h00000010));
      applyStimulus(jal(32'h00000020));
      s = jal(32'h00000030); s.rs = 5'd31; s.rt = 5'd31;
      applyStimulus(s);
      expectAt("full_E", ST_E, 1, 1, 31, 32'h00000038);
      expectAt("full_W", ST_W, 1, 1, 31, 32'h00000018);
      expectAt("full_rs", ST_RS, 1, 1, 0, 32'h00000038);
      s = jal(32'h00000040); s.rst = 1'b1; s.stE = 1'b1; s.stM = 1'b1; s.stW = 1'b1;
      s.rs = 5'd31; s.rt = 5'd31;
      applyStimulus(s);
      expectAt("midrst_E", ST_E, 1, 0, 0, 32'h0);
      expectAt("midrst_M", ST_M, 1, 0, 0, 32'h0);
      expectAt("midrst_W", ST_W, 1, 0, 0, 32'h0);
      expectAt("midrst_rs", ST_RS, 1, 0, 0, 32'h0);
      expectAt("midrst_rt", ST_RT, 1, 0, 0, 32'h0);

      for (int i = 0; i < 6; i++) applyStimulus(idle());

      foreach (sb[i]) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s: expectation for cycle %0d never checked, required wr/hit=%b data=%h",
                  sb[i].name, sb[i].cyc, sb[i].wr, sb[i].data);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
